// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Brief    : Fixed-frequency PWM, 100 duty steps of TICK_DIV clocks each;
//            duty in percent, clamped to 100 and latched once per period.
// Revision : 1.0  initial release
// ============================================================================
module pwm_generator #(
    parameter int TICK_DIV = 25
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [6:0] DUTY_CYCLE,
    output logic       pwm_out,
    output logic       period_start
);

    localparam logic [6:0] c_STEP_LAST = 7'd99;
    localparam logic [6:0] c_DUTY_MAX  = 7'd100;

    logic       r_started;
    logic [6:0] r_step;
    logic [6:0] r_duty;

    logic       w_tick_last;
    logic       w_period_end;
    logic       w_start;
    logic [6:0] w_duty_clamp;
    logic [6:0] w_step_next;
    logic [6:0] w_duty_next;

    // A single-clock step needs no tick counter at all.
    generate
        if (TICK_DIV == 1) begin : g_tick_none
            assign w_tick_last = 1'b1;
        end else begin : g_tick_cnt
            localparam int c_TICK_W = $clog2(TICK_DIV);
            localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

            logic [c_TICK_W-1:0] r_tick;

            always_ff @(posedge clk_50) begin
                if (reset || w_start || (r_tick == c_TICK_LAST)) begin
                    r_tick <= '0;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end

            assign w_tick_last = (r_tick == c_TICK_LAST);
        end
    endgenerate

    // The first edge out of reset starts a period just like a normal wrap.
    assign w_period_end = r_started & w_tick_last & (r_step == c_STEP_LAST);
    assign w_start      = ~r_started | w_period_end;
    assign w_duty_clamp = (DUTY_CYCLE > c_DUTY_MAX) ? c_DUTY_MAX : DUTY_CYCLE;

    always_comb begin
        w_step_next = r_step;
        w_duty_next = r_duty;
        if (w_start) begin
            w_step_next = 7'd0;
            w_duty_next = w_duty_clamp;
        end else if (w_tick_last) begin
            w_step_next = r_step + 7'd1;
        end
    end

    // Outputs reflect the position being entered on this edge.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_started    <= 1'b0;
            r_step       <= 7'd0;
            r_duty       <= 7'd0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_step       <= w_step_next;
            r_duty       <= w_duty_next;
            pwm_out      <= (w_step_next < w_duty_next);
            period_start <= w_start;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_generator
// Brief    : Checks pwm_generator (TICK_DIV=25 and 1) cycle by cycle against
//            a period/offset arithmetic model under directed and random duty.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_generator;

    logic       clk;
    logic       rst;
    logic [6:0] duty;
    logic       pwm_a, ps_a;
    logic       pwm_b, ps_b;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 0;

    int  c_TD [2] = '{25, 1};
    int  m_t  [2] = '{-1, -1};
    int  m_d  [2] = '{0, 0};
    bit  exp_pwm [2] = '{0, 0};
    bit  exp_ps  [2] = '{0, 0};

    pwm_generator #(.TICK_DIV(25)) u_dut_a (
        .clk_50(clk), .reset(rst), .DUTY_CYCLE(duty),
        .pwm_out(pwm_a), .period_start(ps_a)
    );

    pwm_generator #(.TICK_DIV(1)) u_dut_b (
        .clk_50(clk), .reset(rst), .DUTY_CYCLE(duty),
        .pwm_out(pwm_b), .period_start(ps_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Reference: clocks elapsed since period 0, split into period/offset.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int per;
            int off;
            per = 100 * c_TD[k];
            if (rst) begin
                m_t[k]     = -1;
                m_d[k]     = 0;
                exp_pwm[k] = 1'b0;
                exp_ps[k]  = 1'b0;
            end else begin
                m_t[k] = m_t[k] + 1;
                off    = m_t[k] % per;
                if (off == 0) m_d[k] = (int'(duty) > 100) ? 100 : int'(duty);
                exp_pwm[k] = (off < m_d[k] * c_TD[k]);
                exp_ps[k]  = (off == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_td25", pwm_a, exp_pwm[0]);
            check("ps_td25",  ps_a,  exp_ps[0]);
            check("pwm_td1",  pwm_b, exp_pwm[1]);
            check("ps_td1",   ps_b,  exp_ps[1]);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        duty = 7'd20;
        @(negedge clk);
        chk_en = 1'b1;
        run(3);
        rst = 1'b0;

        // Steady 20 %, then 0, 100 and the clamped 125.
        run(5000);
        duty = 7'd0;
        run(5000);
        duty = 7'd100;
        run(5000);
        duty = 7'd125;
        run(5000);

        // 20 -> 50 at clock 100 of a period.
        duty = 7'd20;
        begin
            int guard;
            guard = 0;
            while ((m_t[0] % 2500) != 99 && guard < 6000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 6000) check("sync_timeout", 1'b1, 1'b0);
        end
        duty = 7'd50;
        run(5200);

        // One-cycle reset in the middle of the high phase.
        run(300);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2600);

        // TICK_DIV=1 at 1 %.
        duty = 7'd1;
        run(2600);

        // Randomized duty changes with occasional resets.
        for (int i = 0; i < 14; i++) begin
            duty = 7'($urandom_range(0, 127));
            run($urandom_range(1, 3000));
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
